muldiv_unit: RTL and testbench

Iterative multiply/divide unit holding the architectural HI/LO registers for the pipelined CPU's MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO support. It sits beside the EXE-stage ALU. It accepts an operation from EXE, computes it over WIDTH iterations with a busy/done handshake that the control unit uses to stall, and exposes HI/LO for forwarding to the MFHI/MFLO datapath. Operand width is parametrised; signed and unsigned modes share one datapath.

---
 rtl/muldiv_unit.sv | 124 ++++++++++++
 tb/tb_muldiv_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit holding architectural HI/LO.
// Radix-2 shift-add multiply and restoring divide share one 2*WIDTH accumulator.
//   state | meaning
//   IDLE  | waiting for start; MTHI/MTLO writes accepted
//   CALC  | one multiplier/quotient bit per cycle, WIDTH cycles
//   FIN   | sign fix-up, HI/LO write, done pulse
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             divzero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div, is_signed, sign_a, sign_b, dz;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;

  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [WIDTH:0]     mul_sum, trial, diff;
  logic [2*WIDTH-1:0] step_next, prod_fix;
  logic               flip;

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mag_a   = (!op[0] && a[WIDTH-1]) ? -a : a;
    mag_b   = (!op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial   = acc[2*WIDTH-1:WIDTH-1];
    diff    = trial - {1'b0, opnd};
    if (!is_div)
      step_next = {mul_sum, acc[WIDTH-1:1]};
    else if (diff[WIDTH])
      step_next = {acc[2*WIDTH-2:0], 1'b0};
    else
      step_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    flip     = is_signed && (sign_a ^ sign_b);
    prod_fix = flip ? -acc : acc;
    quo_fix  = flip ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = (is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  assign busy = (state == CALC) || (state == FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      dz        <= 1'b0;
      opnd      <= '0;
      acc       <= '0;
      done      <= 1'b0;
      divzero   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done    <= 1'b0;
      divzero <= 1'b0;
      if (cancel && state != IDLE) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
            if (start && !cancel) begin
              is_div    <= op[1];
              is_signed <= !op[0];
              sign_a    <= !op[0] && a[WIDTH-1];
              sign_b    <= !op[0] && b[WIDTH-1];
              opnd      <= mag_b;
              acc       <= {{WIDTH{1'b0}}, mag_a};
              cnt       <= CW'(WIDTH);
              dz        <= op[1] && (b == '0);
              state     <= (op[1] && (b == '0)) ? FIN : CALC;
            end
          end
          CALC: begin
            acc <= step_next;
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= FIN;
          end
          FIN: begin
            done    <= 1'b1;
            divzero <= dz;
            if (!dz) begin
              if (is_div) begin
                hi <= rem_fix;
                lo <= quo_fix;
              end else begin
                {hi, lo} <= prod_fix;
              end
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench: WIDTH=32 and WIDTH=8 instances against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, mthi = 1'b0, mtlo = 1'b0, cancel = 1'b0, sel8 = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;

  logic        start32, mthi32, mtlo32, start8, mthi8, mtlo8;
  logic        busy32, done32, dz32, busy8, done8, dz8;
  logic [31:0] hi32, lo32;
  logic [7:0]  hi8, lo8;
  logic        cur_busy, cur_done, cur_dz;
  logic [31:0] cur_hi, cur_lo;

  assign start32  = start & ~sel8;
  assign mthi32   = mthi & ~sel8;
  assign mtlo32   = mtlo & ~sel8;
  assign start8   = start & sel8;
  assign mthi8    = mthi & sel8;
  assign mtlo8    = mtlo & sel8;
  assign cur_busy = sel8 ? busy8 : busy32;
  assign cur_done = sel8 ? done8 : done32;
  assign cur_dz   = sel8 ? dz8 : dz32;
  assign cur_hi   = sel8 ? {24'b0, hi8} : hi32;
  assign cur_lo   = sel8 ? {24'b0, lo8} : lo32;

  muldiv_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b),
    .mthi(mthi32), .mtlo(mtlo32), .wdata(wdata), .cancel(cancel),
    .busy(busy32), .done(done32), .divzero(dz32), .hi(hi32), .lo(lo32));

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .a(a[7:0]), .b(b[7:0]),
    .mthi(mthi8), .mtlo(mtlo8), .wdata(wdata[7:0]), .cancel(cancel),
    .busy(busy8), .done(done8), .divzero(dz8), .hi(hi8), .lo(lo8));

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] mhi [2];
  logic [31:0] mlo [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: sign-extend to 64 bits, use native * / %, then slice.
  function automatic void model(input int w, input logic [1:0] o,
                                input logic [31:0] av_in, input logic [31:0] bv_in,
                                input logic [31:0] hi0, input logic [31:0] lo0,
                                output logic [31:0] eh, output logic [31:0] el,
                                output logic edz);
    longint unsigned mask;
    logic [31:0] av, bv;
    longint sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    av = 32'(longint'(av_in) & mask);
    bv = 32'(longint'(bv_in) & mask);
    sa = longint'(av);
    sb = longint'(bv);
    if (!o[0] && av[w-1]) sa = sa - (longint'(1) << w);
    if (!o[0] && bv[w-1]) sb = sb - (longint'(1) << w);
    eh = hi0; el = lo0; edz = 1'b0;
    if (!o[1]) begin
      p  = sa * sb;
      el = 32'(p & mask);
      eh = 32'((p >> w) & mask);
    end else if (bv == 0) begin
      edz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      el = 32'(q & mask);
      eh = 32'(r & mask);
    end
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input bit poke);
    int w, s, n, nb;
    logic [31:0] eh, el;
    logic edz;
    w = sel8 ? 8 : 32;
    s = sel8 ? 1 : 0;
    model(w, o, av, bv, mhi[s], mlo[s], eh, el, edz);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0; nb = 0;
    while (!cur_done && n < 200) begin
      if (cur_busy) nb++;
      if (poke && n == 3) begin
        start = 1'b1; mthi = 1'b1; wdata = 32'hDEADBEEF;
      end else begin
        start = 1'b0; mthi = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0; mthi = 1'b0;
    check("latency", 64'(n), edz ? 64'd1 : 64'(w + 1));
    check("busy_cycles", 64'(nb), edz ? 64'd1 : 64'(w + 1));
    check("hi", 64'(cur_hi), 64'(eh));
    check("lo", 64'(cur_lo), 64'(el));
    check("divzero", 64'(cur_dz), 64'(edz));
    mhi[s] = eh; mlo[s] = el;
    @(posedge clk); #1;
    check("done_one_cycle", 64'(cur_done), 64'd0);
    check("idle_after", 64'(cur_busy), 64'd0);
  endtask

  task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
    int s;
    s = sel8 ? 1 : 0;
    @(negedge clk); mthi = 1'b1; wdata = hv;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = lv;
    @(negedge clk); mtlo = 1'b0;
    mhi[s] = sel8 ? {24'b0, hv[7:0]} : hv;
    mlo[s] = sel8 ? {24'b0, lv[7:0]} : lv;
    check("mthi", 64'(cur_hi), 64'(mhi[s]));
    check("mtlo", 64'(cur_lo), 64'(mlo[s]));
  endtask

  initial begin
    bit seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check("rst_busy", 64'(busy32), 64'd0);
    check("rst_done", 64'(done32), 64'd0);
    check("rst_divzero", 64'(dz32), 64'd0);
    check("rst_hi", 64'(hi32), 64'd0);
    check("rst_lo", 64'(lo32), 64'd0);

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_max_hi", 64'(hi32), 64'hFFFFFFFE);
    check("multu_max_lo", 64'(lo32), 64'h00000001);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 1'b0);
    check("mult_neg_hi", 64'(hi32), 64'hFFFFFFFF);
    check("mult_neg_lo", 64'(lo32), 64'hFFFFFFF1);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_neg_lo", 64'(lo32), 64'hFFFFFFFD);
    check("div_neg_hi", 64'(hi32), 64'hFFFFFFFF);
    run_op(2'b11, 32'd7, 32'd2, 1'b0);
    check("divu_lo", 64'(lo32), 64'd3);
    check("divu_hi", 64'(hi32), 64'd1);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_min_lo", 64'(lo32), 64'h80000000);
    check("div_min_hi", 64'(hi32), 64'd0);

    write_hilo(32'h1234, 32'h5678);
    run_op(2'b11, 32'd99, 32'd0, 1'b0);
    check("dz_hi_kept", 64'(hi32), 64'h1234);
    check("dz_lo_kept", 64'(lo32), 64'h5678);

    // start and MTHI while busy must both be ignored
    run_op(2'b01, 32'd1000, 32'd3000, 1'b1);

    // cancel at iteration 10
    @(negedge clk); op = 2'b01; a = 32'h12345; b = 32'h777; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    check("cancel_busy", 64'(busy32), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done32) seen = 1'b1;
    end
    check("cancel_no_done", 64'(seen), 64'd0);
    check("cancel_hi", 64'(hi32), 64'(mhi[0]));
    check("cancel_lo", 64'(lo32), 64'(mlo[0]));

    // cancel in IDLE blocks start
    @(negedge clk); op = 2'b11; a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    check("cancel_blocks_start", 64'(busy32), 64'd0);

    // async reset mid-CALC
    @(negedge clk); op = 2'b00; a = 32'd77; b = 32'd55; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    check("midrst_busy", 64'(busy32), 64'd0);
    check("midrst_done", 64'(done32), 64'd0);
    check("midrst_hi", 64'(hi32), 64'd0);
    check("midrst_lo", 64'(lo32), 64'd0);
    mhi[0] = '0; mlo[0] = '0; mhi[1] = '0; mlo[1] = '0;
    @(negedge clk); rst = 1'b0;
    run_op(2'b00, 32'hFFFFFF00, 32'h00000100, 1'b0);

    sel8 = 1'b1;
    run_op(2'b00, 32'h80, 32'h80, 1'b0);
    check("w8_mult_hi", 64'(hi8), 64'h40);
    check("w8_mult_lo", 64'(lo8), 64'h00);
    run_op(2'b10, 32'h80, 32'hFF, 1'b0);

    for (int k = 0; k < 60; k++) begin
      sel8 = (k % 2) == 1;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = sel8 ? 32'h80 : 32'h80000000;
        2: rb = 32'hFFFFFFFF;
        3: rb = 32'($urandom_range(1, 5));
        default: ;
      endcase
      run_op(ro, ra, rb, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
